ahb5_sram_slave: RTL and testbench

- AHB5 subordinate: on-chip word-addressed SRAM behind the decoder's HSEL_X output.
- Services single and burst transfers issued by the bus manager.
- Inserts a programmable number of wait states and signals errors with the two-cycle ERROR response.
- Serves as the DUT-side counterpart for the AHB5 manager agent, and as a reusable memory model.

---
 rtl/ahb5_sram_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_ahb5_sram_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb5_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb5_sram_slave
//  Purpose  : AHB5 subordinate wrapping an on-chip word-organised SRAM.
//             Services single and burst beats as independent transfers,
//             inserts WAIT_STATES HREADYOUT-low cycles per OKAY transfer and
//             answers illegal accesses with the two-cycle ERROR response.
//  Ports    :
//    HCLK        in   bus clock, all logic on rising edge
//    HRESETn     in   asynchronous active-low reset
//    HSEL_X      in   decoder select
//    HADDR       in   byte address
//    HTRANS      in   IDLE/BUSY/NONSEQ/SEQ
//    HWRITE      in   1 = write
//    HSIZE       in   0 byte, 1 half, 2 word
//    HBURST      in   burst type (accepted, not decoded)
//    HPROT       in   protection (ignored)
//    HMASTLOCK   in   locked transfer (ignored)
//    HREADY      in   bus-level ready
//    HWDATA      in   write data (data phase)
//    HREADYOUT   out  this subordinate's ready
//    HRESP       out  0 OKAY, 1 ERROR
//    HRDATA      out  read data (valid in final read data-phase cycle)
//  Revision : 1.0  initial release
// ============================================================================
module ahb5_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL_X,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [6:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int WORD_AW = $clog2(MEM_DEPTH);
  localparam int BYTE_AW = WORD_AW + 2;
  // Counter preload: the first WAIT cycle is already one of the wait states.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Address-phase information captured at accept
  logic [BYTE_AW-1:0] addr_q;
  logic               write_q;
  logic [1:0]         size_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic       w_accept;
  logic       w_can_accept;
  logic       w_oor;
  logic       w_size_err;
  logic       w_misalign;
  logic       w_err;
  logic       w_commit;
  logic [3:0] w_lane_en;

  // HBURST/HPROT/HMASTLOCK carry no meaning for a plain memory; SEQ and
  // NONSEQ are handled identically, so HTRANS[0] is not needed either.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  generate
    if (ADDR_WIDTH > BYTE_AW) begin : g_oor_upper
      assign w_oor = |HADDR[ADDR_WIDTH-1:BYTE_AW];
    end else begin : g_oor_none
      assign w_oor = 1'b0;
    end
  endgenerate

  // A new address phase may only be taken while no data phase is stalling;
  // in WAIT/ERR1 HREADY is low on a correct bus anyway.
  assign w_can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                        (state_q == ST_ERR2);
  assign w_accept     = HSEL_X & HREADY & HTRANS[1] & w_can_accept;

  // All error sources lead to the same response, so their priority only
  // matters for documentation; they are simply OR-ed.
  always_comb begin
    w_size_err = (HSIZE > 3'd2);
    w_misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                 ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    w_err      = w_size_err | w_misalign | w_oor;
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
      ST_DONE: begin
        // Read straight from the array: a write committed at the previous
        // edge is already visible, so back-to-back RAW needs no forwarding.
        if (!write_q) begin
          HRDATA = mem_q[addr_q[BYTE_AW-1:2]];
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address-phase capture
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else if (w_accept) begin
      addr_q  <= HADDR[BYTE_AW-1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE[1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Write path: little-endian byte lanes from the captured size/address
  // --------------------------------------------------------------------------
  always_comb begin
    w_lane_en = 4'b0000;
    case (size_q)
      2'd0:    w_lane_en[addr_q[1:0]] = 1'b1;
      2'd1:    w_lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_lane_en = 4'b1111;
    endcase
  end

  // Only DONE commits, so ERROR transfers never write; an asynchronous reset
  // forces IDLE immediately, discarding any pending write.
  assign w_commit = (state_q == ST_DONE) && write_q;

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          mem_q[addr_q[BYTE_AW-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb5_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb5_sram_slave
//  Purpose  : Self-checking bench for ahb5_sram_slave. Two instances are
//             built, one with WAIT_STATES=0 and one with WAIT_STATES=2; a
//             pipelined manager drives one of them at a time and a scoreboard
//             queue holds the expected data-phase result of each accepted
//             transfer.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb5_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel;
  int          dsel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [6:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;

  logic        sel0, sel2;
  logic        ro0, rr0, ro2, rr2;
  logic [31:0] rd0, rd2;

  always #5 HCLK = ~HCLK;

  assign sel0 = hsel && (dsel == 0);
  assign sel2 = hsel && (dsel == 1);

  ahb5_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_X(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(ro0), .HWDATA(HWDATA), .HREADYOUT(ro0), .HRESP(rr0), .HRDATA(rd0)
  );

  ahb5_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_X(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(ro2), .HWDATA(HWDATA), .HREADYOUT(ro2), .HRESP(rr2), .HRDATA(rd2)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic        err;
    logic        use_const;
    logic [31:0] const_rd;
  } xfer_t;

  typedef struct {
    xfer_t       x;
    logic [31:0] rd;
  } exp_t;

  xfer_t       stim_q[$];
  exp_t        exp_q[$];
  logic        bus_active;
  logic [31:0] model_mem [2][256];
  int          n_checks = 0;
  int          n_errors = 0;
  string       cur_test = "none";

  task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [1:0] trans, input logic [2:0] burst, input logic [31:0] wdata,
                     input logic err, input logic use_const, input logic [31:0] const_rd);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.trans = trans; x.burst = burst;
    x.wdata = wdata; x.err = err; x.use_const = use_const; x.const_rd = const_rd;
    stim_q.push_back(x);
  endtask

  task automatic model_write(input xfer_t x);
    int idx = int'(x.addr[9:2]);
    int b   = int'(x.addr[1:0]);
    int h   = int'(x.addr[1]);
    logic [31:0] w = model_mem[dsel][idx];
    case (x.size)
      3'd0:    w[8*b +: 8]   = x.wdata[8*b +: 8];
      3'd1:    w[16*h +: 16] = x.wdata[16*h +: 16];
      default: w             = x.wdata;
    endcase
    model_mem[dsel][idx] = w;
  endtask

  task automatic drive_addr();
    if (stim_q.size() > 0) begin
      hsel = 1'b1; HADDR = stim_q[0].addr; HTRANS = stim_q[0].trans;
      HWRITE = stim_q[0].wr; HSIZE = stim_q[0].size; HBURST = stim_q[0].burst;
      bus_active = 1'b1;
    end else begin
      hsel = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
      HBURST = 3'd0; bus_active = 1'b0;
    end
  endtask

  // Pipelined manager: runs stim_q to completion on the selected instance.
  // Must be entered shortly after a rising edge.
  task automatic run_bus();
    int          ws = (dsel != 0) ? 2 : 0;
    int          dp_cyc = 0;
    int          guard = 0;
    logic        rdy, rsp, exp_rdy, exp_rsp;
    logic [31:0] rdt, exp_rd;
    exp_t        e;
    drive_addr();
    while ((bus_active || exp_q.size() > 0) && guard < 200) begin
      @(negedge HCLK);
      guard++;
      rdy = (dsel != 0) ? ro2 : ro0;
      rsp = (dsel != 0) ? rr2 : rr0;
      rdt = (dsel != 0) ? rd2 : rd0;
      if (exp_q.size() > 0) begin
        dp_cyc++;
        exp_rdy = exp_q[0].x.err ? (dp_cyc == 2) : (dp_cyc == ws + 1);
        exp_rsp = exp_q[0].x.err;
        exp_rd  = (exp_rdy && !exp_q[0].x.err && !exp_q[0].x.wr) ? exp_q[0].rd : 32'h0;
        n_checks++;
        if (rdy !== exp_rdy) begin
          n_errors++;
          $display("FAIL %s hreadyout addr=%h dp_cycle=%0d: got %b expected %b",
                   cur_test, exp_q[0].x.addr, dp_cyc, rdy, exp_rdy);
        end
        n_checks++;
        if (rsp !== exp_rsp) begin
          n_errors++;
          $display("FAIL %s hresp addr=%h dp_cycle=%0d: got %b expected %b",
                   cur_test, exp_q[0].x.addr, dp_cyc, rsp, exp_rsp);
        end
        n_checks++;
        if (rdt !== exp_rd) begin
          n_errors++;
          $display("FAIL %s hrdata addr=%h dp_cycle=%0d: got %h expected %h",
                   cur_test, exp_q[0].x.addr, dp_cyc, rdt, exp_rd);
        end
        if (rdy === 1'b1) begin
          if (!exp_q[0].x.err && exp_q[0].x.wr) model_write(exp_q[0].x);
          void'(exp_q.pop_front());
          dp_cyc = 0;
        end
      end else begin
        n_checks++;
        if (rdy !== 1'b1 || rsp !== 1'b0) begin
          n_errors++;
          $display("FAIL %s idle response: got ready=%b resp=%b expected ready=1 resp=0",
                   cur_test, rdy, rsp);
        end
      end
      if (rdy === 1'b1 && bus_active) begin
        e.x  = stim_q.pop_front();
        e.rd = e.x.use_const ? e.x.const_rd : model_mem[dsel][int'(e.x.addr[9:2])];
        exp_q.push_back(e);
      end
      @(posedge HCLK);
      #1;
      drive_addr();
      HWDATA = (exp_q.size() > 0) ? exp_q[0].x.wdata : 32'h0;
    end
    if (guard >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: got %0d pending transfers expected 0", cur_test,
               stim_q.size() + exp_q.size());
      stim_q.delete();
      exp_q.delete();
      drive_addr();
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    HRESETn = 1'b0;
    hsel = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = 7'h0; HMASTLOCK = 1'b0; HWDATA = 32'h0; dsel = 0;
    bus_active = 1'b0;
    repeat (2) @(negedge HCLK);
    n_checks++;
    if (ro0 !== 1'b1 || ro2 !== 1'b1) begin
      n_errors++; $display("FAIL reset hreadyout: got %b/%b expected 1/1", ro0, ro2);
    end
    n_checks++;
    if (rr0 !== 1'b0 || rr2 !== 1'b0) begin
      n_errors++; $display("FAIL reset hresp: got %b/%b expected 0/0", rr0, rr2);
    end
    n_checks++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
      n_errors++; $display("FAIL reset hrdata: got %h/%h expected 0/0", rd0, rd2);
    end
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_zero_wait();
    cur_test = "zero_wait"; dsel = 0;
    add(1'b1, 32'h10, 3'd2, 2'b10, 3'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h10, 3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    run_bus();
  endtask

  task automatic test_wait_states();
    cur_test = "wait_states"; dsel = 1;
    add(1'b1, 32'h20, 3'd2, 2'b10, 3'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h20, 3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
    run_bus();
  endtask

  task automatic test_subword();
    cur_test = "subword"; dsel = 1;
    add(1'b1, 32'h40, 3'd2, 2'b10, 3'd0, 32'h11223344, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h41, 3'd0, 2'b10, 3'd0, 32'h0000AA00, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h42, 3'd1, 2'b10, 3'd0, 32'hBEEF0000, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h40, 3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b1, 32'hBEEFAA44);
    add(1'b1, 32'h47, 3'd0, 2'b10, 3'd0, 32'h77000000, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h44, 3'd1, 2'b10, 3'd0, 32'h00005566, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h44, 3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b0, 32'h0);
    run_bus();
  endtask

  task automatic test_errors();
    cur_test = "errors"; dsel = 1;
    add(1'b1, 32'h3FC, 3'd2, 2'b10, 3'd0, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h400, 3'd2, 2'b10, 3'd0, 32'h0,        1'b1, 1'b0, 32'h0);
    add(1'b0, 32'h3FC, 3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b1, 32'h0BADC0DE);
    add(1'b1, 32'h00,  3'd2, 2'b10, 3'd0, 32'h55AA55AA, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h02,  3'd2, 2'b10, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h05,  3'd1, 2'b10, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    add(1'b0, 32'h08,  3'd3, 2'b10, 3'd0, 32'h0,        1'b1, 1'b0, 32'h0);
    add(1'b0, 32'h00,  3'd2, 2'b10, 3'd0, 32'h0,        1'b0, 1'b1, 32'h55AA55AA);
    run_bus();
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      cur_test = (d == 0) ? "back_to_back_ws0" : "back_to_back_ws2";
      dsel = d;
      for (int i = 0; i < 4; i++) begin
        add(1'b1, 32'h80 + 32'(4*i), 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'd3,
            32'hA0000000 + 32'(i) + 32'(16*d), 1'b0, 1'b0, 32'h0);
      end
      add(1'b0, 32'h80, 3'd2, 2'b10, 3'd0, 32'h0, 1'b0, 1'b1, 32'hA0000000 + 32'(16*d));
      add(1'b1, 32'h90, 3'd2, 2'b10, 3'd0, 32'h12345678, 1'b0, 1'b0, 32'h0);
      add(1'b0, 32'h90, 3'd2, 2'b10, 3'd0, 32'h0, 1'b0, 1'b1, 32'h12345678);
      add(1'b0, 32'h8C, 3'd2, 2'b10, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      run_bus();
    end
  endtask

  task automatic test_reset_midwait();
    cur_test = "reset_midwait"; dsel = 1;
    add(1'b1, 32'h50, 3'd2, 2'b10, 3'd0, 32'h5050A0A0, 1'b0, 1'b0, 32'h0);
    run_bus();
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h50; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    hsel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFFFF0000;
    @(negedge HCLK);
    n_checks++;
    if (ro2 !== 1'b0) begin
      n_errors++; $display("FAIL reset_midwait in_wait hreadyout: got %b expected 0", ro2);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (ro2 !== 1'b1 || rr2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midwait async outputs: got ready=%b resp=%b expected ready=1 resp=0",
               ro2, rr2);
    end
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    HWDATA = 32'h0;
    @(posedge HCLK);
    #1;
    add(1'b0, 32'h50, 3'd2, 2'b10, 3'd0, 32'h0, 1'b0, 1'b1, 32'h5050A0A0);
    run_bus();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_midwait();
    repeat (2) @(posedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
